// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and a size-legality helper.
package data_mem_responder_pkg;

    // RISC-V load/store func3 encoding of the access size
    typedef logic [2:0] data_size_t;

    localparam data_size_t MEM_B  = 3'b000;
    localparam data_size_t MEM_H  = 3'b001;
    localparam data_size_t MEM_W  = 3'b010;
    localparam data_size_t MEM_BU = 3'b100;
    localparam data_size_t MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Unsigned sizes only make sense for loads; 011/110/111 are never legal
    function automatic logic size_legal(input data_size_t size, input logic write);
        logic ok;
        case (size)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = ~write;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering between a 32-bit storage word and a
// B/H/W access: load extract + extend, store byte enables + replicated
// write data, and natural-alignment check.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  data_size_t  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_data_o,
    output logic        misaligned_o
);

    logic [31:0] shifted_s;

    // Bring the addressed lane down to bit 0, then sign/zero-extend
    always_comb begin
        shifted_s   = rword_i >> {addr_lo_i, 3'b000};
        load_data_o = 32'h0000_0000;
        case (size_i)
            MEM_B:   load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            MEM_BU:  load_data_o = {24'h00_0000, shifted_s[7:0]};
            MEM_H:   load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            MEM_HU:  load_data_o = {16'h0000, shifted_s[15:0]};
            MEM_W:   load_data_o = rword_i;
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replicate store data across lanes so byte enables alone pick the target
    always_comb begin
        byte_en_o    = 4'b0000;
        store_data_o = 32'h0000_0000;
        case (size_i)
            MEM_B: begin
                byte_en_o    = 4'b0001 << addr_lo_i;
                store_data_o = {4{wdata_i[7:0]}};
            end
            MEM_H: begin
                byte_en_o    = 4'b0011 << addr_lo_i;
                store_data_o = {2{wdata_i[15:0]}};
            end
            MEM_W: begin
                byte_en_o    = 4'b1111;
                store_data_o = wdata_i;
            end
            default: begin
                byte_en_o    = 4'b0000;
                store_data_o = 32'h0000_0000;
            end
        endcase
    end

    // Halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            MEM_H, MEM_HU: misaligned_o = addr_lo_i[0];
            MEM_W:         misaligned_o = |addr_lo_i;
            default:       misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the MEM-stage load/store port: accepts one access per
// handshake, waits WAIT_CYCLES, then presents a one-cycle response. Stores
// commit on the edge leaving RESP; loads read pre-write storage.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetIn,
    input  logic        reqValid,
    input  logic        reqWrite,
    input  logic [2:0]  reqSize,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        reqReady,
    output logic        respValid,
    output logic [31:0] respRdata,
    output logic        respErr,
    output logic        memStall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    data_size_t  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        eff_wr_s;
    data_size_t  eff_size_s;
    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic        in_range_s;
    logic [31:0] rword_s;
    logic [31:0] load_data_s;
    logic [3:0]  byte_en_s;
    logic [31:0] store_data_s;
    logic        misaligned_s;
    logic        req_err_s;
    logic        enter_resp_s;

    // In IDLE the live request is decoded (needed for zero-wait builds); afterwards the latch
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_wr_s    = reqWrite;
            eff_size_s  = reqSize;
            eff_addr_s  = reqAddr;
            eff_wdata_s = reqWdata;
        end else begin
            eff_wr_s    = wr_q;
            eff_size_s  = size_q;
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
        end
    end

    // Word fetch with range guard so an out-of-range index never aliases storage
    always_comb begin
        in_range_s = (eff_addr_s[31:2] < 30'(DEPTH));
        if (in_range_s) begin
            rword_s = mem_q[eff_addr_s[AW+1:2]];
        end else begin
            rword_s = 32'h0000_0000;
        end
    end

    mem_lane_align u_lane_align (
        .size_i       (eff_size_s),
        .addr_lo_i    (eff_addr_s[1:0]),
        .rword_i      (rword_s),
        .wdata_i      (eff_wdata_s),
        .load_data_o  (load_data_s),
        .byte_en_o    (byte_en_s),
        .store_data_o (store_data_s),
        .misaligned_o (misaligned_s)
    );

    assign req_err_s = misaligned_s | ~in_range_s | ~size_legal(eff_size_s, eff_wr_s);

    // Next-state, wait counter, request latch and registered response values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    wr_d    = reqWrite;
                    size_d  = reqSize;
                    addr_d  = reqAddr;
                    wdata_d = reqWdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = enter_resp_s;
        if (enter_resp_s) begin
            err_d = req_err_s;
            if (!eff_wr_s && !req_err_s) begin
                rdata_d = load_data_s;
            end else begin
                rdata_d = 32'h0000_0000;
            end
        end else begin
            err_d   = 1'b0;
            rdata_d = 32'h0000_0000;
        end
    end

    // Control state and response registers; reset discards any pending access
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Commit an error-free store on the edge leaving RESP; storage is never reset
    always_ff @(posedge clk) begin
        if (state_q == ST_RESP && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem_q[addr_q[AW+1:2]][8*i +: 8] <= store_data_s[8*i +: 8];
                end
            end
        end
    end

    assign reqReady  = (state_q == ST_IDLE) & reqValid;
    assign respValid = valid_q;
    assign respRdata = rdata_q;
    assign respErr   = err_q;
    // Independent of reqReady so the hazard logic sees no combinational loop
    assign memStall  = reqValid & ~valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing request fields, each with its own valid.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        resetIn;
    logic        v2, v0;
    logic        reqWrite;
    logic [2:0]  reqSize;
    logic [31:0] reqAddr, reqWdata;
    logic        rdy2, rv2, err2, st2;
    logic [31:0] rd2;
    logic        rdy0, rv0, err0, st0;
    logic [31:0] rd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .resetIn(resetIn), .reqValid(v2), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqReady(rdy2), .respValid(rv2), .respRdata(rd2), .respErr(err2),
        .memStall(st2)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .resetIn(resetIn), .reqValid(v0), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqReady(rdy0), .respValid(rv0), .respRdata(rd0), .respErr(err0),
        .memStall(st0)
    );

    // Issue one request to the selected instance; returns data, error,
    // accept-to-response latency and whether memStall behaved while waiting.
    task automatic drive_req(input bit sel, input logic wr, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er,
                             output int lat, output bit stall_ok);
        int guard;
        rd = 32'h0; er = 1'b0; lat = -1; stall_ok = 1'b1;
        @(negedge clk);
        reqWrite = wr; reqSize = sz; reqAddr = addr; reqWdata = wd;
        if (sel) v0 = 1'b1; else v2 = 1'b1;
        guard = 0;
        while (!(sel ? rdy0 : rdy2) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!(sel ? rdy0 : rdy2)) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: reqReady got 0 required 1 addr %h", addr);
            v0 = 1'b0; v2 = 1'b0;
            return;
        end
        if ((sel ? st0 : st2) !== 1'b1) stall_ok = 1'b0;
        @(posedge clk); #1;
        // Request fields must be ignored once accepted
        reqWrite = ~wr; reqSize = 3'b111; reqAddr = ~addr; reqWdata = ~wd;
        guard = 1;
        while (guard < 20) begin
            if ((sel ? rv0 : rv2) === 1'b1) begin
                lat = guard;
                rd  = sel ? rd0 : rd2;
                er  = sel ? err0 : err2;
                if ((sel ? st0 : st2) !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if ((sel ? st0 : st2) !== 1'b1) stall_ok = 1'b0;
            if ((sel ? rd0 : rd2) !== 32'h0 || (sel ? err0 : err2) !== 1'b0) stall_ok = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: respValid got 0 required 1 addr %h", addr);
        end
        @(negedge clk);
        v0 = 1'b0; v2 = 1'b0;
    endtask

    task automatic test_reset();
        resetIn = 1'b0; v2 = 1'b0; v0 = 1'b0;
        reqWrite = 1'b0; reqSize = 3'b000; reqAddr = 32'h0; reqWdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({rv2, err2, rdy2, st2, rd2} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_w2: got %h required %h", {rv2, err2, rdy2, st2, rd2}, 36'h0);
        end
        n_tests++;
        if ({rv0, err0, rdy0, st0, rd0} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_w0: got %h required %h", {rv0, err0, rdy0, st0, rd0}, 36'h0);
        end
        @(negedge clk);
        resetIn = 1'b1;
    endtask

    task automatic test_load_word();
        logic [31:0] rd; logic er; int lat; bit sok;
        drive_req(1'b0, 1'b1, MEM_W, 32'h10, 32'h11223344, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL sw_resp: got rd %h err %b lat %0d required 00000000 0 3", rd, er, lat);
        end
        drive_req(1'b0, 1'b0, MEM_W, 32'h10, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_data: got %h err %b required 11223344 0", rd, er);
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL lw_latency: got %0d required 3", lat);
        end
        n_tests++;
        if (!sok) begin
            n_fail++;
            $display("FAIL lw_stall: got stall_ok 0 required 1");
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd; logic er; int lat; bit sok;
        logic [2:0]  szs [6] = '{MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_B, MEM_BU};
        logic [31:0] ads [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h12, 32'h11};
        logic [31:0] exs [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h00007F01, 32'hFFFFFFFF, 32'h0000007F};
        drive_req(1'b0, 1'b1, MEM_W, 32'h10, 32'h80FF7F01, rd, er, lat, sok);
        for (int i = 0; i < 6; i++) begin
            drive_req(1'b0, 1'b0, szs[i], ads[i], 32'h0, rd, er, lat, sok);
            n_tests++;
            if (rd !== exs[i] || er !== 1'b0 || lat != 3) begin
                n_fail++;
                $display("FAIL subword_load_%0d: got %h err %b lat %0d required %h 0 3",
                         i, rd, er, lat, exs[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er; int lat; bit sok;
        drive_req(1'b0, 1'b1, MEM_W, 32'h10, 32'h11223344, rd, er, lat, sok);
        drive_req(1'b0, 1'b1, MEM_B, 32'h11, 32'hFFFFFFAB, rd, er, lat, sok);
        n_tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_resp: got rd %h err %b required 00000000 0", rd, er);
        end
        drive_req(1'b0, 1'b0, MEM_W, 32'h10, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL sb_readback: got %h required 1122ab44", rd);
        end
        drive_req(1'b0, 1'b1, MEM_H, 32'h12, 32'h1234BEEF, rd, er, lat, sok);
        drive_req(1'b0, 1'b0, MEM_W, 32'h10, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'hBEEFAB44) begin
            n_fail++;
            $display("FAIL sh_readback: got %h required beefab44", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit sok;
        logic        ewr [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  esz [6] = '{MEM_W, MEM_H, MEM_W, MEM_W, 3'b011, MEM_BU};
        logic [31:0] ead [6] = '{32'h12, 32'h13, 32'h400, 32'h400, 32'h10, 32'h10};
        drive_req(1'b0, 1'b1, MEM_W, 32'h0, 32'h0BADF00D, rd, er, lat, sok);
        for (int i = 0; i < 6; i++) begin
            drive_req(1'b0, ewr[i], esz[i], ead[i], 32'hFFFFFFFF, rd, er, lat, sok);
            n_tests++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin
                n_fail++;
                $display("FAIL error_case_%0d: got err %b rd %h lat %0d required 1 00000000 3",
                         i, er, rd, lat);
            end
        end
        drive_req(1'b0, 1'b0, MEM_W, 32'h10, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'hBEEFAB44 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write_w4: got %h required beefab44", rd);
        end
        drive_req(1'b0, 1'b0, MEM_W, 32'h0, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_alias_w0: got %h required 0badf00d", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; bit sok;
        drive_req(1'b1, 1'b1, MEM_W, 32'h0, 32'hCAFEF00D, rd, er, lat, sok);
        n_tests++;
        if (lat != 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL w0_store_latency: got %0d err %b required 1 0", lat, er);
        end
        drive_req(1'b1, 1'b1, MEM_W, 32'h4, 32'h01234567, rd, er, lat, sok);
        @(negedge clk);
        reqWrite = 1'b0; reqSize = MEM_W; reqAddr = 32'h0; v0 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (rv0 !== 1'b1 || rd0 !== 32'hCAFEF00D || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cycle1: got valid %b data %h ready %b required 1 cafef00d 0",
                     rv0, rd0, rdy0);
        end
        @(negedge clk);
        reqAddr = 32'h4;
        n_tests++;
        if (rdy0 !== 1'b0 || st0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_resp_ready: got ready %b stall %b required 0 0", rdy0, st0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rv0 !== 1'b0 || rdy0 !== 1'b1 || st0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_cycle2: got valid %b ready %b stall %b required 0 1 1", rv0, rdy0, st0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rv0 !== 1'b1 || rd0 !== 32'h01234567) begin
            n_fail++;
            $display("FAIL b2b_cycle3: got valid %b data %h required 1 01234567", rv0, rd0);
        end
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; bit sok;
        bit seen;
        drive_req(1'b0, 1'b1, MEM_W, 32'h20, 32'h13572468, rd, er, lat, sok);
        @(negedge clk);
        reqWrite = 1'b1; reqSize = MEM_W; reqAddr = 32'h20; reqWdata = 32'hDEADBEEF; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        @(posedge clk); #2;
        resetIn = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        if (rv2 !== 1'b0) seen = 1'b1;
        @(negedge clk);
        resetIn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rv2 !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midop_no_resp: got respValid 1 required 0");
        end
        drive_req(1'b0, 1'b0, MEM_W, 32'h20, 32'h0, rd, er, lat, sok);
        n_tests++;
        if (rd !== 32'h13572468 || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL midop_mem_kept: got %h err %b lat %0d required 13572468 0 3", rd, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
